// File: rtl/tdm_rx.sv
// Two-slot TDM receiver: oversamples sclk/fclk/din in the mclk domain,
// deserialises each frame into two words and tracks frame lock.
module tdm_rx #(
    parameter int G_BITS      = 16,
    parameter int G_MAX_SLOTS = 64
) (
    input  logic              in_mclk,
    input  logic              in_rst_n,
    input  logic              in_sclk,
    input  logic              in_fclk,
    input  logic              in_din,
    output logic [G_BITS-1:0] out_frame_1,
    output logic [G_BITS-1:0] out_frame_2,
    output logic              out_frame_strobe,
    output logic              out_locked,
    output logic              out_frame_error
);

    localparam int W  = 2 * G_BITS;
    localparam int CW = $clog2(W + 1);
    localparam int SW = $clog2(G_MAX_SLOTS + 1);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_SHIFT    = 2'd1;
    localparam logic [1:0] ST_WAIT     = 2'd2;

    logic          sclk_s1, sclk_s2, sclk_s3;
    logic          fclk_s1, fclk_s2;
    logic          din_s1, din_s2;
    logic [1:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [SW-1:0] slot_cnt;
    logic [SW-1:0] slot_nxt;
    // The final data bit goes straight to the outputs, so W-1 bits suffice.
    logic [W-2:0]  shreg;
    logic          ev;
    logic          timeout;

    always_ff @(posedge in_mclk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            fclk_s1 <= 1'b0;
            fclk_s2 <= 1'b0;
            din_s1  <= 1'b0;
            din_s2  <= 1'b0;
        end else begin
            sclk_s1 <= in_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            fclk_s1 <= in_fclk;
            fclk_s2 <= fclk_s1;
            din_s1  <= in_din;
            din_s2  <= din_s1;
        end
    end

    always_comb begin
        ev       = sclk_s2 & ~sclk_s3;
        slot_nxt = slot_cnt;
        if (slot_cnt != SW'(G_MAX_SLOTS)) begin
            slot_nxt = slot_cnt + SW'(1);
        end
        timeout = (slot_nxt == SW'(G_MAX_SLOTS));
    end

    always_ff @(posedge in_mclk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state            <= ST_UNLOCKED;
            bit_cnt          <= '0;
            slot_cnt         <= '0;
            shreg            <= '0;
            out_frame_1      <= '0;
            out_frame_2      <= '0;
            out_frame_strobe <= 1'b0;
            out_locked       <= 1'b0;
            out_frame_error  <= 1'b0;
        end else begin
            out_frame_strobe <= 1'b0;
            out_frame_error  <= 1'b0;
            if (ev) begin
                slot_cnt <= fclk_s2 ? '0 : slot_nxt;
                case (state)
                    ST_UNLOCKED: begin
                        if (fclk_s2) begin
                            state      <= ST_SHIFT;
                            bit_cnt    <= '0;
                            out_locked <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (fclk_s2) begin
                            out_frame_error <= 1'b1;
                            bit_cnt         <= '0;
                        end else if (timeout) begin
                            state      <= ST_UNLOCKED;
                            out_locked <= 1'b0;
                        end else begin
                            shreg   <= {shreg[W-3:0], din_s2};
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == CW'(W - 1)) begin
                                {out_frame_1, out_frame_2} <= {shreg, din_s2};
                                out_frame_strobe <= 1'b1;
                                state            <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (fclk_s2) begin
                            state   <= ST_SHIFT;
                            bit_cnt <= '0;
                        end else if (timeout) begin
                            state      <= ST_UNLOCKED;
                            out_locked <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= ST_UNLOCKED;
                        out_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
